cla_addsub_pipe: RTL and testbench

- Two-stage pipelined carry-lookahead adder/subtractor.
- Consumes parallel-prefix group generate/propagate vectors and produces sum, carry-out, signed overflow and zero flags.
- Sits downstream of operand staging in the arithmetic datapath. Valid/ready handshakes on both the input and output sides.

---
 rtl/cla_pkg.sv | 21 ++
 rtl/cla_addsub_pipe_if.sv | 43 ++++
 rtl/cla_prefix_gp.sv | 30 +++
 rtl/cla_addsub_pipe.sv | 123 ++++++++++++
 tb/tb_cla_addsub_pipe.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared constants and the stage-1 register bundle for the pipelined CLA adder/subtractor.
// The sat field exists only when CLA_ADDSUB_SAT_EN is defined.
package cla_pkg;

   localparam int CLA_WIDTH     = 21;
   localparam int CLA_MAX_WIDTH = 64;

   // Vectors are sized for the widest legal configuration; narrower instances use the low bits
   typedef struct packed {
      logic [CLA_MAX_WIDTH-1:0] p;
      logic [CLA_MAX_WIDTH-1:0] grp_g;
      logic [CLA_MAX_WIDTH-1:0] grp_p;
      logic                     c0;
      logic                     a_sign;
      logic                     b_sign;
`ifdef CLA_ADDSUB_SAT_EN
      logic                     sat;
`endif
   } s1_reg_t;

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand and result handshake bundle for cla_addsub_pipe.
// sat_en is present only when CLA_ADDSUB_SAT_EN is defined.
interface cla_addsub_pipe_if
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
`ifdef CLA_ADDSUB_SAT_EN
   logic             sat_en;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub,
`ifdef CLA_ADDSUB_SAT_EN
      output sat_en,
`endif
      output out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub,
`ifdef CLA_ADDSUB_SAT_EN
      input  sat_en,
`endif
      input  out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );

endinterface

// File: rtl/cla_prefix_gp.sv
// Kogge-Stone prefix network: grp_g[i]/grp_p[i] are the group generate/propagate of bits 0..i.
module cla_prefix_gp
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
) (
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] grp_g,
   output logic [WIDTH-1:0] grp_p
);

   logic [WIDTH-1:0] gk;
   logic [WIDTH-1:0] pk;

   // Walking i downward lets each level update in place: bit i-d still holds the previous level
   always_comb begin
      gk = g;
      pk = p;
      for (int d = 1; d < WIDTH; d = d * 2) begin
         for (int i = WIDTH - 1; i >= d; i--) begin
            gk[i] = gk[i] | (pk[i] & gk[i-d]);
            pk[i] = pk[i] & pk[i-d];
         end
      end
      grp_g = gk;
      grp_p = pk;
   end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Define CLA_ADDSUB_SAT_EN to add the sat_en input and signed clamping of overflowed results.
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
) (
   input logic              clk,
   input logic              rst,
   cla_addsub_pipe_if.slave io
);

   logic             s1_valid;
   logic             s2_valid;
   logic             s2_advance;
   logic             s1_load;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] bit_p;
   logic [WIDTH-1:0] bit_g;
   logic [WIDTH-1:0] grp_g;
   logic [WIDTH-1:0] grp_p;
   s1_reg_t          s1_d;
   s1_reg_t          s1_q;
   logic [WIDTH-1:0] s1_p;
   logic [WIDTH-1:0] s1_grp_g;
   logic [WIDTH-1:0] s1_grp_p;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] raw_sum;
   logic [WIDTH-1:0] s2_sum;
   logic             raw_ovf;
   logic             unused_bits;

   assign s2_advance    = s1_valid & (~s2_valid | io.out_ready);
   assign io.in_ready   = ~s1_valid | s2_advance;
   assign s1_load       = io.in_valid & io.in_ready;
   assign io.out_valid  = s2_valid;

   // Subtraction is A + ~B + 1, so the carry-in is forced high and cin is ignored
   assign b_eff = io.sub ? ~io.b : io.b;
   assign bit_p = io.a ^ b_eff;
   assign bit_g = io.a & b_eff;

   cla_prefix_gp #(
      .WIDTH(WIDTH)
   ) u_prefix (
      .g     (bit_g),
      .p     (bit_p),
      .grp_g (grp_g),
      .grp_p (grp_p)
   );

   always_comb begin
      s1_d        = '0;
      s1_d.p      = CLA_MAX_WIDTH'(bit_p);
      s1_d.grp_g  = CLA_MAX_WIDTH'(grp_g);
      s1_d.grp_p  = CLA_MAX_WIDTH'(grp_p);
      s1_d.c0     = io.sub | io.cin;
      s1_d.a_sign = io.a[WIDTH-1];
      s1_d.b_sign = b_eff[WIDTH-1];
`ifdef CLA_ADDSUB_SAT_EN
      s1_d.sat    = io.sat_en;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
      end else if (s2_advance) begin
         s1_valid <= 1'b0;
      end
      if (s1_load) begin
         s1_q <= s1_d;
      end
   end

   assign s1_p     = s1_q.p[WIDTH-1:0];
   assign s1_grp_g = s1_q.grp_g[WIDTH-1:0];
   assign s1_grp_p = s1_q.grp_p[WIDTH-1:0];

   // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out
   assign carry   = {s1_grp_g | (s1_grp_p & {WIDTH{s1_q.c0}}), s1_q.c0};
   assign raw_sum = s1_p ^ carry[WIDTH-1:0];
   assign raw_ovf = carry[WIDTH] ^ carry[WIDTH-1];

`ifdef CLA_ADDSUB_SAT_EN
   // An overflow only happens when A and the effective B share a sign, so A's sign picks the rail
   assign s2_sum = (s1_q.sat & raw_ovf)
                 ? (s1_q.a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                 : raw_sum;
`else
   assign s2_sum = raw_sum;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         io.sum   <= '0;
         io.cout  <= 1'b0;
         io.ovf   <= 1'b0;
         io.zero  <= 1'b0;
      end else if (s2_advance) begin
         s2_valid <= 1'b1;
         io.sum   <= s2_sum;
         io.cout  <= carry[WIDTH];
         io.ovf   <= raw_ovf;
         io.zero  <= ~|s2_sum;
      end else if (io.out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   generate
      if (WIDTH < CLA_MAX_WIDTH) begin : g_pad
         assign unused_bits = ^{s1_q.p[CLA_MAX_WIDTH-1:WIDTH], s1_q.grp_g[CLA_MAX_WIDTH-1:WIDTH],
                                s1_q.grp_p[CLA_MAX_WIDTH-1:WIDTH], s1_q.a_sign, s1_q.b_sign};
      end else begin : g_nopad
         assign unused_bits = s1_q.a_sign ^ s1_q.b_sign;
      end
   endgenerate

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe against an arithmetic reference model.
// Define CLA_ADDSUB_SAT_EN for both bench and RTL to also cover saturation.
module tb_cla_addsub_pipe;
   import cla_pkg::*;

   localparam int W = CLA_WIDTH;
`ifdef CLA_ADDSUB_SAT_EN
   localparam bit SAT_BUILD = 1'b1;
`else
   localparam bit SAT_BUILD = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic         sat;
      res_t         exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   vec_t vecs[$];

   cla_addsub_pipe_if #(.WIDTH(W)) bus ();

   cla_addsub_pipe #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: plain integer arithmetic on unsigned and signed interpretations
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub, input logic sat);
      longint ua, ub, sa, sb, sr, full, smax, smin, span;
      res_t   r;
      span = longint'(1) << W;
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = (ua > smax) ? ua - span : ua;
      sb   = (ub > smax) ? ub - span : ub;
      if (sub) begin
         full   = ua - ub;
         r.cout = (ua >= ub);
         sr     = sa - sb;
      end else begin
         full   = ua + ub + longint'(cin);
         r.cout = (full >= span);
         sr     = sa + sb + longint'(cin);
      end
      r.sum = full[W-1:0];
      r.ovf = (sr > smax) || (sr < smin);
      if (sat && r.ovf) r.sum = (sr > smax) ? smax[W-1:0] : smin[W-1:0];
      r.zero = (r.sum == '0);
      return r;
   endfunction

   function automatic vec_t mk(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input logic sat,
                               input logic [W-1:0] s, input logic co, input logic ov, input logic z);
      vec_t v;
      v.name = n; v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sat = sat;
      v.exp  = {s, co, ov, z};
      return v;
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   function automatic res_t observed();
      return {bus.sum, bus.cout, bus.ovf, bus.zero};
   endfunction

   task automatic apply_stimulus(input logic valid, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input logic sat, input logic ordy);
      bus.in_valid  = valid;
      bus.a         = a;
      bus.b         = b;
      bus.cin       = cin;
      bus.sub       = sub;
      bus.out_ready = ordy;
`ifdef CLA_ADDSUB_SAT_EN
      bus.sat_en    = sat;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (observed() !== '0) begin
         errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", observed());
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic run_vectors();
      foreach (vecs[i]) begin
         apply_stimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sat, 1'b1);
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL %s_accept: in_ready got %b expected 1", vecs[i].name, bus.in_ready);
         end
         step();
         apply_stimulus(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sat, 1'b1);
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL %s_early: out_valid got %b expected 0", vecs[i].name, bus.out_valid);
         end
         step();
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL %s_latency: out_valid got %b expected 1", vecs[i].name, bus.out_valid);
         end
         checks++;
         if (observed() !== vecs[i].exp) begin
            errors++;
            $display("[TB] FAIL %s_result: got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                     vecs[i].name, bus.sum, bus.cout, bus.ovf, bus.zero,
                     vecs[i].exp.sum, vecs[i].exp.cout, vecs[i].exp.ovf, vecs[i].exp.zero);
         end
         step();
      end
      vecs.delete();
   endtask

   task automatic test_directed();
      vecs.push_back(mk("add_ovf",    21'h0FFFFF, 21'h000001, 1'b0, 1'b0, 1'b0, 21'h100000, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk("add_wrap",   21'h1FFFFF, 21'h000001, 1'b0, 1'b0, 1'b0, 21'h000000, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk("add_cin",    21'h1FFFFF, 21'h000000, 1'b1, 1'b0, 1'b0, 21'h000000, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk("sub_neg",    21'h000005, 21'h000007, 1'b0, 1'b1, 1'b0, 21'h1FFFFE, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk("sub_ovf",    21'h100000, 21'h000001, 1'b0, 1'b1, 1'b0, 21'h0FFFFF, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk("sub_no_cin", 21'h000009, 21'h000004, 1'b1, 1'b1, 1'b0, 21'h000005, 1'b1, 1'b0, 1'b0));
      run_vectors();
   endtask

`ifdef CLA_ADDSUB_SAT_EN
   task automatic test_saturation();
      vecs.push_back(mk("sat_pos",    21'h0FFFFF, 21'h000001, 1'b0, 1'b0, 1'b1, 21'h0FFFFF, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk("sat_neg",    21'h100000, 21'h000001, 1'b0, 1'b1, 1'b1, 21'h100000, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk("sat_no_ovf", 21'h000005, 21'h000007, 1'b0, 1'b1, 1'b1, 21'h1FFFFE, 1'b0, 1'b0, 1'b0));
      run_vectors();
   endtask
`endif

   task automatic test_backpressure();
      logic [W-1:0] ba[6];
      logic [W-1:0] bb[6];
      logic         bc[6];
      logic         bs[6];
      logic         bt[6];
      int           sent = 0;
      int           got = 0;
      res_t         held = '0;
      for (int i = 0; i < 6; i++) begin
         ba[i] = pick_operand(); bb[i] = pick_operand();
         bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1)); bt[i] = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 40 && got < 6; c++) begin
         if (sent < 6) apply_stimulus(1'b1, ba[sent], bb[sent], bc[sent], bs[sent], bt[sent], c >= 4);
         else          apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, c >= 4);
         @(negedge clk);
         if (c == 2 || c == 3) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++; $display("[TB] FAIL bp_in_ready_c%0d: got %b expected 0", c, bus.in_ready);
            end
            checks++;
            if (sent != 2) begin
               errors++; $display("[TB] FAIL bp_buffered_c%0d: got %0d beats accepted expected 2", c, sent);
            end
            checks++;
            if (bus.out_valid !== 1'b1) begin
               errors++; $display("[TB] FAIL bp_out_valid_c%0d: got %b expected 1", c, bus.out_valid);
            end
         end
         if (c == 2) held = observed();
         if (c == 3) begin
            checks++;
            if (observed() !== held) begin
               errors++; $display("[TB] FAIL bp_stable: got %h expected %h", observed(), held);
            end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("[TB] FAIL bp_spurious: got result %h expected none", observed());
            end else begin
               res_t e;
               e = exp_q.pop_front();
               if (observed() !== e) begin
                  errors++; $display("[TB] FAIL bp_order_%0d: got %h expected %h", got, observed(), e);
               end
            end
            got++;
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            exp_q.push_back(model(ba[sent], bb[sent], bc[sent], bs[sent], bt[sent] & SAT_BUILD));
            sent++;
         end
         step();
      end
      checks++;
      if (got != 6 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL bp_count: got %0d results (%0d pending) expected 6 (0 pending)", got, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_midflight();
      res_t e;
      apply_stimulus(1'b1, 21'h000ABC, 21'h000123, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      apply_stimulus(1'b1, 21'h001000, 21'h000001, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL rst_inflight: out_valid got %b expected 1", bus.out_valid);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_flush_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (observed() !== '0) begin
         errors++; $display("[TB] FAIL rst_flush_outputs: got %h expected 0", observed());
      end
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_ghost_c%0d: out_valid got %b expected 0", c, bus.out_valid);
         end
         step();
      end
      e = model(21'h012345, 21'h00ABCD, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 21'h012345, 21'h00ABCD, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_fresh_early: out_valid got %b expected 0", bus.out_valid);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || observed() !== e) begin
         errors++; $display("[TB] FAIL rst_fresh_result: got valid=%b res=%h expected valid=1 res=%h",
                            bus.out_valid, observed(), e);
      end
      step();
   endtask

   task automatic test_random();
      logic [W-1:0] ra = '0;
      logic [W-1:0] rb = '0;
      logic         rc = 1'b0;
      logic         rs = 1'b0;
      logic         rt = 1'b0;
      logic         have = 1'b0;
      int           pops = 0;
      for (int c = 0; c < 400; c++) begin
         if (!have && $urandom_range(0, 9) < 7) begin
            ra = pick_operand(); rb = pick_operand();
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1)); rt = 1'($urandom_range(0, 1));
            have = 1'b1;
         end
         apply_stimulus(have, ra, rb, rc, rs, rt, $urandom_range(0, 9) < 7);
         @(negedge clk);
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("[TB] FAIL rnd_spurious: got result %h expected none", observed());
            end else begin
               res_t e;
               e = exp_q.pop_front();
               if (observed() !== e) begin
                  errors++; $display("[TB] FAIL rnd_result_%0d: got %h expected %h", pops, observed(), e);
               end
            end
            pops++;
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            exp_q.push_back(model(ra, rb, rc, rs, rt & SAT_BUILD));
            have = 1'b0;
         end
         step();
      end
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            res_t e;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
               errors++; $display("[TB] FAIL rnd_drain_%0d: got %h expected %h", pops, observed(), e);
            end
            pops++;
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL rnd_drain_end: got %0d pending, out_valid=%b expected 0 pending, out_valid=0",
                            exp_q.size(), bus.out_valid);
      end
      exp_q.delete();
      step();
   endtask

   initial begin
      $display("[TB] cla_addsub_pipe bench, WIDTH=%0d, saturation build=%0d", W, SAT_BUILD);
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midflight();
`ifdef CLA_ADDSUB_SAT_EN
      test_saturation();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
